// File: rtl/tone_frame_generator_pkg.sv
// Shared types and constants for the tone frame generator.
// The phase increments assume a 24-bit accumulator and a 10 MS/s sample rate.
package tone_frame_generator_pkg;

    localparam int N_TONES = 8;
    localparam int INC_W   = 24;

    // Entry 0 is silence. Entries 1..7 are the detector tone bins 8, 16, 24, 32, 48,
    // 64 and 96 of a 6250-sample recording: round(bin * 2^24 / 6250).
    localparam logic [INC_W-1:0] TONE_INC [N_TONES] = '{
        24'd0,
        24'd21475,
        24'd42950,
        24'd64425,
        24'd85899,
        24'd128849,
        24'd171799,
        24'd257698
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tone_frame_generator_if.sv
// Command and sample-stream signals of the tone frame generator.
//
// Handshake rule for both channels: a transfer happens on a rising clock edge where
// valid && ready are both high. Once a source raises valid, it holds valid and its
// payload (data, last, command fields) unchanged until that transfer. Ready may
// change freely and never depends on a transfer completing.
//
// master: the generator (accepts commands, sources samples).
// slave : the environment (issues commands, sinks samples).
interface tone_frame_generator_if #(
    parameter int SAMPLE_W = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [2:0]                 cmd_tone_ident;
    logic [31:0]                cmd_length;
    logic                       m_valid;
    logic                       m_ready;
    logic signed [SAMPLE_W-1:0] m_data;
    logic                       m_last;

    modport master (
        input  cmd_valid, cmd_tone_ident, cmd_length, m_ready,
        output cmd_ready, m_valid, m_data, m_last
    );

    modport slave (
        output cmd_valid, cmd_tone_ident, cmd_length, m_ready,
        input  cmd_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/tone_frame_generator_quarter_sine_rom.sv
// Quarter-wave sine ROM with mirror and negate; only built when SINE_LUT_EN is defined.
// phase_top is the top 10 bits of the phase accumulator: [9] selects the negative
// half cycle, [8] mirrors the quarter, [7:0] addresses the 256-entry table.
// Table entries sit at bin centres and come from Bhaskara's sine approximation,
// evaluated at elaboration, so the hardware is a plain constant table.
`ifdef SINE_LUT_EN
module quarter_sine_rom #(
    parameter int SAMPLE_W = 16
) (
    input  logic [9:0]                 phase_top,
    output logic signed [SAMPLE_W-1:0] sample
);

    localparam longint PEAK = (longint'(1) << (SAMPLE_W - 1)) - 1;

    // Angle x in 1/1024 half-turn units: sin ~ 16x(P-x) / (5P^2 - 4x(P-x)), P = 1024.
    function automatic logic [SAMPLE_W-1:0] quarter_sine(input int idx);
        longint x;
        longint q;
        x = longint'(2 * idx + 1);
        q = x * (64'sd1024 - x);
        return SAMPLE_W'((PEAK * 64'sd16 * q) / (64'sd5242880 - 64'sd4 * q));
    endfunction

    logic [SAMPLE_W-1:0] rom [256];
    logic [7:0]          addr;
    logic [SAMPLE_W-1:0] mag;

    for (genvar g = 0; g < 256; g++) begin : g_rom
        assign rom[g] = quarter_sine(g);
    end

    // Fold the phase into the first quadrant, look up, then restore the sign.
    always_comb begin
        addr   = phase_top[8] ? ~phase_top[7:0] : phase_top[7:0];
        mag    = rom[addr];
        sample = phase_top[9] ? -$signed(mag) : $signed(mag);
    end

endmodule
`endif

// File: rtl/tone_frame_generator.sv
// Tone frame generator: accepts one tone command and emits a frame of PCM samples
// on a valid/ready/last stream, pacing samples CLKS_PER_SAMPLE clocks apart.
// Build option SINE_LUT_EN: sine samples from quarter_sine_rom; otherwise a square
// wave of +/-AMPLITUDE. Handshake timing is the same in both builds.
module tone_frame_generator
    import tone_frame_generator_pkg::*;
#(
    parameter int                         SAMPLE_W        = 16,
    parameter int                         PHASE_W         = 24,
    parameter int                         CLKS_PER_SAMPLE = 10,
    parameter logic signed [SAMPLE_W-1:0] AMPLITUDE       = 16'sh3FFF
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    tone_frame_generator_if.master bus,
    output logic                   busy,
    output logic                   done,
    output state_t                 dbg_state
);

    localparam int PACE_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(CLKS_PER_SAMPLE - 1);
    // The handshake cycle itself is the first pacing slot, so with ready held high
    // samples leave exactly every CLKS_PER_SAMPLE clocks.
    localparam logic [PACE_W-1:0] PACE_RESTART = (CLKS_PER_SAMPLE > 1) ? PACE_W'(1) : '0;

    state_t                     state_q, state_d;
    logic [2:0]                 ident_q, ident_d;
    logic [31:0]                length_q, length_d;
    logic [31:0]                sample_idx_q, sample_idx_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [PACE_W-1:0]          pace_q, pace_d;
    logic                       valid_q, valid_d;
    logic                       last_q, last_d;
    logic signed [SAMPLE_W-1:0] data_q, data_d;
    logic signed [SAMPLE_W-1:0] wave_sample;
    logic [PHASE_W-1:0]         phase_inc;

    assign phase_inc = PHASE_W'(TONE_INC[ident_q]);

`ifdef SINE_LUT_EN
    quarter_sine_rom #(
        .SAMPLE_W (SAMPLE_W)
    ) u_rom (
        .phase_top (phase_q[PHASE_W-1 -: 10]),
        .sample    (wave_sample)
    );
`else
    assign wave_sample = phase_q[PHASE_W-1] ? -AMPLITUDE : AMPLITUDE;
`endif

    // Next-state and datapath: command accept, sample pacing, stream handshake.
    always_comb begin
        state_d      = state_q;
        ident_d      = ident_q;
        length_d     = length_q;
        sample_idx_d = sample_idx_q;
        phase_d      = phase_q;
        pace_d       = pace_q;
        valid_d      = valid_q;
        last_d       = last_q;
        data_d       = data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ident_d      = bus.cmd_tone_ident;
                    length_d     = bus.cmd_length;
                    phase_d      = '0;
                    sample_idx_d = '0;
                    pace_d       = '0;
                    state_d      = (bus.cmd_length == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!valid_q) begin
                    if (pace_q == PACE_LAST) begin
                        valid_d = 1'b1;
                        data_d  = (ident_q == 3'd0) ? '0 : wave_sample;
                        last_d  = (sample_idx_q == length_q - 32'd1);
                        pace_d  = '0;
                    end else begin
                        pace_d = pace_q + 1'b1;
                    end
                end else if (bus.m_ready) begin
                    valid_d      = 1'b0;
                    last_d       = 1'b0;
                    phase_d      = phase_q + phase_inc;
                    sample_idx_d = sample_idx_q + 32'd1;
                    pace_d       = PACE_RESTART;
                    if (last_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            ident_q      <= '0;
            length_q     <= '0;
            sample_idx_q <= '0;
            phase_q      <= '0;
            pace_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            ident_q      <= ident_d;
            length_q     <= length_d;
            sample_idx_q <= sample_idx_d;
            phase_q      <= phase_d;
            pace_q       <= pace_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            data_q       <= data_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.m_valid   = valid_q;
    assign bus.m_data    = data_q;
    assign bus.m_last    = last_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign dbg_state     = state_q;

endmodule
